mult_accum: RTL and testbench

MULT_ACCUM -- requirements
Module: mult_accum

---
 rtl/mult_accum_if.sv | 27 ++
 rtl/mult_accum.sv | 108 ++++++++++
 tb/tb_mult_accum.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_accum_if.sv
// Product-in / sum-out handshake bundle for mult_accum.
// Both channels use the same rule: a transfer happens on a rising edge where valid && ready.
interface mult_accum_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
);
  logic                   p_valid;
  logic                   p_ready;
  logic [2*WIDTH-1:0]     p_data;
  logic                   p_last;
  logic                   acc_valid;
  logic                   acc_ready;
  logic [ACC_WIDTH-1:0]   acc_data;
  logic [7:0]             acc_count;
  logic                   acc_ovf;
  logic                   acc_trunc;

  modport master (
    output p_valid, p_data, p_last, acc_ready,
    input  p_ready, acc_valid, acc_data, acc_count, acc_ovf, acc_trunc
  );

  modport slave (
    input  p_valid, p_data, p_last, acc_ready,
    output p_ready, acc_valid, acc_data, acc_count, acc_ovf, acc_trunc
  );
endinterface

// File: rtl/mult_accum.sv
// Accumulates a burst of unsigned products and presents the sum until it is taken.
// Bursts end on p_last or after MAX_BEATS beats; clear aborts everything synchronously.
module mult_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  mult_accum_if.slave       bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [7:0]             count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   trunc_q, trunc_d;

  logic [2*WIDTH-1:0]     p_data_w;
  logic [ACC_WIDTH-1:0]   p_ext;
  logic [ACC_WIDTH-1:0]   base_acc;
  logic [7:0]             base_count;
  logic                   base_ovf;
  logic [ACC_WIDTH:0]     sum;
  logic                   p_ready_w;
  logic                   beat;

  assign p_data_w  = bus.p_data;
  assign p_ext     = ACC_WIDTH'(p_data_w);
  assign p_ready_w = (state_q != HOLD);
  assign beat      = bus.p_valid && p_ready_w;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;
    // A beat taken in IDLE starts from zero, so IDLE and ACCUM share one datapath.
    base_acc   = (state_q == IDLE) ? '0 : acc_q;
    base_count = (state_q == IDLE) ? 8'd0 : count_q;
    base_ovf   = (state_q == IDLE) ? 1'b0 : ovf_q;
    sum        = {1'b0, base_acc} + {1'b0, p_ext};
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = 8'd0;
      ovf_d   = 1'b0;
      trunc_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            acc_d   = sum[ACC_WIDTH-1:0];
            count_d = base_count + 8'd1;
            ovf_d   = base_ovf | sum[ACC_WIDTH];
            trunc_d = 1'b0;
            if (bus.p_last || (count_d == MAX_CNT)) begin
              state_d = HOLD;
              trunc_d = !bus.p_last;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= 8'd0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
    end
  end

  assign bus.p_ready   = p_ready_w;
  assign bus.acc_valid = (state_q == HOLD);
  assign bus.acc_data  = acc_q;
  assign bus.acc_count = count_q;
  assign bus.acc_ovf   = ovf_q;
  assign bus.acc_trunc = trunc_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mult_accum.sv
// Bench for mult_accum: directed scenarios plus a randomized run against a burst-level model.
module tb_mult_accum;
  localparam int W  = 8;
  localparam int AW = 16;
  localparam int MB = 4;
  localparam int RW = AW + 10;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [1:0] dbg_state;
  int         checks;
  int         passes;
  logic [RW-1:0] exp_q[$];

  mult_accum_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

  mult_accum #(.WIDTH(W), .ACC_WIDTH(AW), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic logic [RW-1:0] mk(input bit trunc, input bit ovf,
                                       input int cnt, input logic [AW-1:0] data);
    return {trunc, ovf, 8'(cnt), data};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {bus.acc_trunc, bus.acc_ovf, bus.acc_count, bus.acc_data};
  endfunction

  // drivers: every task starts and ends just after a falling edge
  task automatic beat(input logic [2*W-1:0] d, input bit last);
    bus.p_valid = 1'b1;
    bus.p_data  = d;
    bus.p_last  = last;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.p_valid = 1'b0;
    bus.p_data  = 16'($urandom);
    bus.p_last  = 1'($urandom);
  endtask

  task automatic drain();
    bus.acc_ready = 1'b1;
    @(negedge clk);
    bus.acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== '0 || bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1)
      $display("FAIL reset_values: got res=%h v=%b r=%b, expected res=0 v=0 r=1",
               observed(), bus.acc_valid, bus.p_ready);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    beat(16'h0006, 1'b0);
    beat(16'h000C, 1'b0);
    checks++;
    if (bus.acc_valid !== 1'b0) $display("FAIL basic_early_valid: got %b, expected 0", bus.acc_valid);
    else passes++;
    beat(16'h0014, 1'b1);
    idle();
    checks++;
    if (bus.acc_valid !== 1'b1 || bus.p_ready !== 1'b0)
      $display("FAIL basic_valid: got v=%b r=%b, expected v=1 r=0", bus.acc_valid, bus.p_ready);
    else passes++;
    checks++;
    if (observed() !== mk(0, 0, 3, 16'h0026))
      $display("FAIL basic_result: got %h, expected %h", observed(), mk(0, 0, 3, 16'h0026));
    else passes++;
    drain();
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1)
      $display("FAIL basic_release: got v=%b r=%b, expected v=0 r=1", bus.acc_valid, bus.p_ready);
    else passes++;
  endtask

  task automatic test_overflow();
    beat(16'hFE01, 1'b0);
    beat(16'hFE01, 1'b1);
    idle();
    checks++;
    if (bus.acc_valid !== 1'b1 || observed() !== mk(0, 1, 2, 16'hFC02))
      $display("FAIL overflow_result: got v=%b res=%h, expected v=1 res=%h",
               bus.acc_valid, observed(), mk(0, 1, 2, 16'hFC02));
    else passes++;
    drain();
  endtask

  task automatic test_trunc_hold();
    for (int i = 0; i < MB; i++) beat(16'h0001, 1'b0);
    // fifth beat stays presented while the result waits
    bus.p_valid = 1'b1;
    bus.p_data  = 16'h0001;
    bus.p_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.acc_valid !== 1'b1 || bus.p_ready !== 1'b0 || observed() !== mk(1, 0, 4, 16'h0004))
        $display("FAIL trunc_hold_cycle%0d: got v=%b r=%b res=%h, expected v=1 r=0 res=%h",
                 i, bus.acc_valid, bus.p_ready, observed(), mk(1, 0, 4, 16'h0004));
      else passes++;
      @(negedge clk);
    end
    bus.acc_ready = 1'b1;
    @(negedge clk);
    bus.acc_ready = 1'b0;
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1)
      $display("FAIL trunc_release: got v=%b r=%b, expected v=0 r=1", bus.acc_valid, bus.p_ready);
    else passes++;
    @(negedge clk);
    beat(16'h0002, 1'b1);
    idle();
    checks++;
    if (bus.acc_valid !== 1'b1 || observed() !== mk(0, 0, 2, 16'h0003))
      $display("FAIL trunc_next_burst: got v=%b res=%h, expected v=1 res=%h",
               bus.acc_valid, observed(), mk(0, 0, 2, 16'h0003));
    else passes++;
    drain();
  endtask

  task automatic test_clear();
    beat(16'h0010, 1'b0);
    beat(16'h0020, 1'b0);
    bus.p_valid = 1'b1;
    bus.p_data  = 16'h0055;
    bus.p_last  = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle();
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1 || observed() !== '0)
      $display("FAIL clear_burst: got v=%b r=%b res=%h, expected v=0 r=1 res=0",
               bus.acc_valid, bus.p_ready, observed());
    else passes++;
    beat(16'h0007, 1'b1);
    idle();
    checks++;
    if (bus.acc_valid !== 1'b1 || observed() !== mk(0, 0, 1, 16'h0007))
      $display("FAIL clear_after: got v=%b res=%h, expected v=1 res=%h",
               bus.acc_valid, observed(), mk(0, 0, 1, 16'h0007));
    else passes++;
    // clear while a result is pending discards it
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (bus.acc_valid !== 1'b0 || observed() !== '0)
      $display("FAIL clear_hold: got v=%b res=%h, expected v=0 res=0", bus.acc_valid, observed());
    else passes++;
  endtask

  task automatic test_reset_mid();
    beat(16'h0030, 1'b0);
    beat(16'h0040, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1 || observed() !== '0)
      $display("FAIL reset_async: got v=%b r=%b res=%h, expected v=0 r=1 res=0",
               bus.acc_valid, bus.p_ready, observed());
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    beat(16'h0009, 1'b1);
    idle();
    checks++;
    if (bus.acc_valid !== 1'b1 || observed() !== mk(0, 0, 1, 16'h0009))
      $display("FAIL reset_after: got v=%b res=%h, expected v=1 res=%h",
               bus.acc_valid, observed(), mk(0, 0, 1, 16'h0009));
    else passes++;
    drain();
  endtask

  // Reference: a burst is the list of beats taken since the last result;
  // its result is the plain sum, reduced mod 2^AW, overflow when the sum reaches 2^AW.
  task automatic test_random(input int cycles);
    bit     pending;
    longint burst_sum;
    int     burst_len;
    pending   = 1'b0;
    burst_sum = 0;
    burst_len = 0;
    exp_q.delete();
    for (int c = 0; c < cycles; c++) begin
      checks++;
      if (bus.acc_valid !== pending || bus.p_ready !== !pending)
        $display("FAIL random_flow c%0d: got v=%b r=%b, expected v=%b r=%b",
                 c, bus.acc_valid, bus.p_ready, pending, !pending);
      else passes++;
      if (pending) begin
        checks++;
        if (observed() !== exp_q[0])
          $display("FAIL random_result c%0d: got %h, expected %h", c, observed(), exp_q[0]);
        else passes++;
      end
      bus.p_valid   = ($urandom_range(0, 3) != 0);
      bus.p_data    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255))
                                                  : 16'($urandom);
      bus.p_last    = ($urandom_range(0, 3) == 0);
      bus.acc_ready = ($urandom_range(0, 2) == 0);
      clear         = ($urandom_range(0, 59) == 0);
      if (clear) begin
        pending   = 1'b0;
        burst_sum = 0;
        burst_len = 0;
        exp_q.delete();
      end else if (pending) begin
        if (bus.acc_ready) begin
          pending = 1'b0;
          void'(exp_q.pop_front());
        end
      end else if (bus.p_valid) begin
        burst_sum += longint'(bus.p_data);
        burst_len++;
        if (bus.p_last || burst_len == MB) begin
          exp_q.push_back(mk(!bus.p_last, burst_sum >= (64'd1 << AW), burst_len,
                             AW'(burst_sum % (64'd1 << AW))));
          pending   = 1'b1;
          burst_sum = 0;
          burst_len = 0;
        end
      end
      @(negedge clk);
    end
    idle();
    bus.acc_ready = 1'b0;
    clear         = 1'b0;
  endtask

  initial begin
    checks        = 0;
    passes        = 0;
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.p_valid   = 1'b0;
    bus.p_data    = '0;
    bus.p_last    = 1'b0;
    bus.acc_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_trunc_hold();
    test_clear();
    test_reset_mid();
    test_random(600);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
